// File: rtl/ref_clk_gen_pkg.sv
// Shared types and constants for the numerically-controlled reference clock.
// Holds the controller state encoding and the dither LFSR polynomial and seed.
package ref_clk_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        STOP = 2'd3
    } rcg_state_e;

    // Right-shift Galois mask for x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/ref_clk_gen_lfsr16.sv
// lfsr16: 16-bit Galois LFSR used as accumulator dither; built only with REF_CLK_GEN_DITHER_EN.
// Latency: new value every clkin cycle. Backpressure: none, free running from the seed.
`ifdef REF_CLK_GEN_DITHER_EN
module lfsr16
    import ref_clk_gen_pkg::*;
(
    input  logic        clkin,
    input  logic        rst,
    output logic [15:0] q
);

    always_ff @(posedge clkin) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_POLY : 16'h0000);
        end
    end

endmodule
`endif

// File: rtl/ref_clk_gen.sv
// ref_clk_gen: phase-accumulator reference clock, clkout = acc MSB; REF_CLK_GEN_DITHER_EN adds LFSR dither.
// Latency: running 1 cycle after en; first clkout high ceil(2^(ACC_W-1)/FCW)+1 cycles after en.
// Backpressure: cfg_ready low while an FCW update or a stop is waiting for accumulator wrap.
module ref_clk_gen
    import ref_clk_gen_pkg::*;
#(
    parameter int               ACC_W       = 32,
    parameter logic [ACC_W-1:0] DEFAULT_FCW = {{(ACC_W-1){1'b0}}, 1'b1} << (ACC_W-3),
    parameter int               CNT_W       = 16
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [ACC_W-1:0] cfg_word,
    output logic             cfg_ready,
    output logic             clkout,
    output logic             running,
    output logic [CNT_W-1:0] rise_cnt
);

    localparam logic [ACC_W-1:0] FCW_MAX = {1'b1, {(ACC_W-1){1'b0}}};

    rcg_state_e       state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [ACC_W-1:0] fcw, fcw_nxt;
    logic [ACC_W-1:0] pend_fcw, pend_fcw_nxt;
    logic             pend_vld, pend_vld_nxt;
    logic             clkout_q;
    logic [CNT_W-1:0] rise_cnt_r;
    logic [ACC_W:0]   sum;
    logic             wrap;
    logic             accept;
    logic [ACC_W-1:0] word_sat;

`ifdef REF_CLK_GEN_DITHER_EN
    logic [15:0] lfsr_q;

    lfsr16 u_lfsr (
        .clkin (clkin),
        .rst   (rst),
        .q     (lfsr_q)
    );

    assign sum = {1'b0, acc} + {1'b0, fcw} + {{(ACC_W-3){1'b0}}, lfsr_q[3:0]};
`else
    assign sum = {1'b0, acc} + {1'b0, fcw};
`endif

    assign wrap      = sum[ACC_W];
    assign cfg_ready = (state == IDLE) || (state == RUN);
    assign accept    = cfg_valid && cfg_ready;
    assign word_sat  = (cfg_word > FCW_MAX) ? FCW_MAX : cfg_word;

    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        fcw_nxt      = fcw;
        pend_fcw_nxt = pend_fcw;
        pend_vld_nxt = pend_vld;

        case (state)
            IDLE: begin
                acc_nxt = '0;
                if (accept) fcw_nxt = word_sat;
                if (en) state_nxt = RUN;
            end
            RUN: begin
                acc_nxt = sum[ACC_W-1:0];
                if (accept) begin
                    pend_fcw_nxt = word_sat;
                    pend_vld_nxt = 1'b1;
                    state_nxt    = PEND;
                end
                if (!en) state_nxt = STOP;
            end
            PEND: begin
                acc_nxt = sum[ACC_W-1:0];
                if (!en) begin
                    state_nxt = STOP;
                end else if (wrap) begin
                    fcw_nxt      = pend_fcw;
                    pend_vld_nxt = 1'b0;
                    state_nxt    = RUN;
                end
            end
            STOP: begin
                acc_nxt = sum[ACC_W-1:0];
                if (wrap) begin
                    acc_nxt      = '0;
                    if (pend_vld) fcw_nxt = pend_fcw;
                    pend_vld_nxt = 1'b0;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A zero FCW never wraps, so a stop request would otherwise hang.
        if ((state != IDLE) && !en && (fcw == '0)) begin
            acc_nxt      = '0;
            pend_vld_nxt = 1'b0;
            state_nxt    = IDLE;
            if (accept) begin
                fcw_nxt = word_sat;
            end else if (pend_vld) begin
                fcw_nxt = pend_fcw;
            end
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            fcw        <= DEFAULT_FCW;
            pend_fcw   <= '0;
            pend_vld   <= 1'b0;
            clkout_q   <= 1'b0;
            rise_cnt_r <= '0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            fcw        <= fcw_nxt;
            pend_fcw   <= pend_fcw_nxt;
            pend_vld   <= pend_vld_nxt;
            clkout_q   <= acc[ACC_W-1];
            rise_cnt_r <= rise_cnt_r + {{(CNT_W-1){1'b0}}, (acc[ACC_W-1] & ~clkout_q)};
        end
    end

    assign clkout   = acc[ACC_W-1];
    assign running  = (state != IDLE);
    assign rise_cnt = rise_cnt_r;

endmodule

// File: tb/tb_ref_clk_gen.sv
// Bench for ref_clk_gen at ACC_W=8: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a flag-based arithmetic model.
module tb_ref_clk_gen;

    localparam int ACC_W = 8;
    localparam int CNT_W = 16;
    localparam int MOD   = 256;
    localparam int HALF  = 128;

    logic             clkin     = 1'b0;
    logic             rst       = 1'b1;
    logic             en        = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [ACC_W-1:0] cfg_word  = '0;
    logic             cfg_ready;
    logic             clkout;
    logic             running;
    logic [CNT_W-1:0] rise_cnt;

    int errors = 0;
    int checks = 0;

    ref_clk_gen #(
        .ACC_W       (ACC_W),
        .DEFAULT_FCW (8'd32),
        .CNT_W       (CNT_W)
    ) dut (
        .clkin     (clkin),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_word  (cfg_word),
        .cfg_ready (cfg_ready),
        .clkout    (clkout),
        .running   (running),
        .rise_cnt  (rise_cnt)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase value, tuning word and three flags (running, stopping, word waiting).
    int m_acc, m_fcw, m_pend, m_rise;
    bit m_run, m_stop, m_hasp, m_prev, m_valid;

    function automatic int sat(input int w);
        return (w > HALF) ? HALF : w;
    endfunction

    function automatic int exp_ready();
        return (!m_run || (!m_stop && !m_hasp)) ? 1 : 0;
    endfunction

    always @(posedge clkin) begin : model
        int  w, sum;
        bit  take, carry, hi;
        if (rst) begin
            m_acc = 0; m_fcw = 32; m_pend = 0; m_rise = 0;
            m_run = 0; m_stop = 0; m_hasp = 0; m_prev = 0;
            m_valid = 1;
        end else if (m_valid) begin
            w     = sat(int'(cfg_word));
            take  = cfg_valid && (exp_ready() == 1);
            hi    = (m_acc >= HALF);
            if (hi && !m_prev) m_rise++;
            m_prev = hi;
            sum   = m_acc + m_fcw;
            carry = (sum >= MOD);
            if (!m_run) begin
                m_acc = 0;
                if (take) m_fcw = w;
                if (en) m_run = 1;
            end else if (!en && m_fcw == 0) begin
                if (take) m_fcw = w;
                else if (m_hasp) m_fcw = m_pend;
                m_acc = 0; m_run = 0; m_stop = 0; m_hasp = 0;
            end else if (m_stop) begin
                if (carry) begin
                    if (m_hasp) m_fcw = m_pend;
                    m_acc = 0; m_run = 0; m_stop = 0; m_hasp = 0;
                end else begin
                    m_acc = sum;
                end
            end else if (m_hasp) begin
                m_acc = sum % MOD;
                if (!en) m_stop = 1;
                else if (carry) begin
                    m_fcw  = m_pend;
                    m_hasp = 0;
                end
            end else begin
                m_acc = sum % MOD;
                if (take) begin
                    m_pend = w;
                    m_hasp = 1;
                end
                if (!en) m_stop = 1;
            end
        end
    end

    always @(negedge clkin) begin
        if (m_valid) begin
            chk("clkout",    int'(clkout),    (m_acc >= HALF) ? 1 : 0);
            chk("running",   int'(running),   m_run ? 1 : 0);
            chk("cfg_ready", int'(cfg_ready), exp_ready());
            chk("rise_cnt",  int'(rise_cnt),  m_rise % 65536);
        end
    end

    task automatic tick();
        @(negedge clkin);
        #1;
    endtask

    initial begin
        int highs;

        // Reset values
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_clkout",  int'(clkout),    0);
        chk("rst_running", int'(running),   0);
        chk("rst_ready",   int'(cfg_ready), 1);
        chk("rst_rise",    int'(rise_cnt),  0);

        // Default FCW 32 run, mid-period retune to 64, then reset while pending
        en    = 1'b1;
        highs = 0;
        for (int n = 1; n <= 54; n++) begin
            tick();
            if (n >= 2 && n <= 33 && clkout) highs++;
            if (n == 1)  chk("run_after_en",    int'(running), 1);
            if (n == 4)  chk("first_high_n4",   int'(clkout), 0);
            if (n == 5)  chk("first_high_n5",   int'(clkout), 1);
            if (n == 9)  chk("fall_n9",         int'(clkout), 0);
            if (n == 13) chk("second_high_n13", int'(clkout), 1);
            if (n == 33) begin
                chk("duty_32cyc", highs, 16);
                chk("rise_cnt_32", int'(rise_cnt), 4);
            end
            if (n == 35) begin
                cfg_valid = 1'b1;
                cfg_word  = 8'd64;
            end
            if (n == 36) begin
                chk("pend_ready_low", int'(cfg_ready), 0);
                cfg_valid = 1'b0;
                highs = 0;
            end
            if (n >= 37 && n <= 40 && clkout) highs++;
            if (n == 40) begin
                chk("old_period_high", highs, 4);
                chk("pend_ready_n40", int'(cfg_ready), 0);
            end
            if (n == 41) begin
                chk("wrap_ready", int'(cfg_ready), 1);
                chk("wrap_low",   int'(clkout), 0);
            end
            if (n == 43) chk("new_high_n43", int'(clkout), 1);
            if (n == 45) chk("new_low_n45",  int'(clkout), 0);
            if (n == 47) begin
                chk("new_high_n47", int'(clkout), 1);
                chk("rise_cnt_47",  int'(rise_cnt), 6);
                cfg_valid = 1'b1;
                cfg_word  = 8'h10;
            end
            if (n == 48) begin
                chk("pend_before_rst", int'(cfg_ready), 0);
                rst = 1'b1;
            end
            if (n == 49) begin
                chk("mid_rst_clkout",  int'(clkout),    0);
                chk("mid_rst_running", int'(running),   0);
                chk("mid_rst_ready",   int'(cfg_ready), 1);
                chk("mid_rst_rise",    int'(rise_cnt),  0);
                rst       = 1'b0;
                cfg_valid = 1'b0;
            end
            if (n == 53) chk("post_rst_n53", int'(clkout), 0);
            if (n == 54) chk("post_rst_n54", int'(clkout), 1);
        end

        // Stop from acc=0x90 at FCW 32 (reach it via FCW 0x70 then a retune)
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0; cfg_valid = 1'b1; cfg_word = 8'h70;
        tick();
        cfg_valid = 1'b0; en = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 1) begin
                cfg_valid = 1'b1;
                cfg_word  = 8'd32;
            end
            if (t == 2) cfg_valid = 1'b0;
            if (t == 3) chk("pend_ready_t3", int'(cfg_ready), 0);
            if (t == 4) chk("retuned_ready", int'(cfg_ready), 1);
            if (t == 6) begin
                chk("acc90_high", int'(clkout), 1);
                en = 1'b0;
            end
            if (t == 7) chk("stop_ready", int'(cfg_ready), 0);
            if (t == 9) begin
                chk("stop_high_t9", int'(clkout), 1);
                chk("stop_run_t9",  int'(running), 1);
            end
            if (t == 10) begin
                chk("stopped_clk",   int'(clkout), 0);
                chk("stopped_run",   int'(running), 0);
                chk("stopped_ready", int'(cfg_ready), 1);
            end
        end

        // Oversized word saturates to 0x80: clkout toggles every cycle
        cfg_valid = 1'b1; cfg_word = 8'hC0;
        tick();
        cfg_valid = 1'b0; en = 1'b1;
        for (int u = 1; u <= 7; u++) begin
            tick();
            if (u == 2) chk("sat_u2", int'(clkout), 1);
            if (u == 3) chk("sat_u3", int'(clkout), 0);
            if (u == 4) chk("sat_u4", int'(clkout), 1);
            if (u == 5) begin
                chk("sat_u5", int'(clkout), 0);
                en = 1'b0;
            end
            if (u == 7) chk("sat_stop_run", int'(running), 0);
        end

        // Zero FCW: no edges, immediate return to IDLE on en fall
        cfg_valid = 1'b1; cfg_word = 8'h00;
        tick();
        cfg_valid = 1'b0; en = 1'b1;
        for (int v = 1; v <= 6; v++) begin
            tick();
            if (v == 1) chk("zero_running", int'(running), 1);
            if (v == 5) begin
                chk("zero_clk_low", int'(clkout), 0);
                en = 1'b0;
            end
            if (v == 6) begin
                chk("zero_idle_run",   int'(running), 0);
                chk("zero_idle_ready", int'(cfg_ready), 1);
            end
        end

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            tick();
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) en = ~en;
            cfg_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) cfg_word = 8'h00;
            else cfg_word = 8'($urandom_range(1, 255));
        end
        rst = 1'b0;
        cfg_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
